// File: rtl/coder8b10b_pkg.sv
// rtl/coder8b10b_pkg.sv - shared 8b10b K-code constants and tx sequencer state encoding
package coder8b10b_pkg;

  // Control symbols, all sent with the K flag set
  localparam logic [7:0] K28_5 = 8'hBC;  // comma / idle
  localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
  localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
  localparam logic [7:0] K28_0 = 8'h1C;  // clock-compensation skip
  localparam logic [7:0] K23_7 = 8'hF7;  // stall filler inside a packet

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SOF     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_EOF     = 3'd4,
    ST_SKIP    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/tx_link_sequencer_skip_timer.sv
// rtl/tx_link_sequencer_skip_timer.sv - free-running skip interval counter with sticky request flag
module skip_timer #(
  parameter int SKIP_INTERVAL = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic pending
);

  localparam logic [15:0] LAST = 16'(SKIP_INTERVAL - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        expire;

  // Count to LAST then wrap; a fresh expiry wins over a same-cycle clear so it is never lost
  always_comb begin
    expire    = (cnt_q == LAST);
    cnt_d     = expire ? 16'd0 : cnt_q + 16'd1;
    pending_d = pending_q;
    if (clear)  pending_d = 1'b0;
    if (expire) pending_d = 1'b1;
  end

  // Counter and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 16'd0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/tx_link_sequencer.sv
// rtl/tx_link_sequencer.sv - chooses the byte/K symbol fed to the 8b10b encoder each cycle
module tx_link_sequencer
  import coder8b10b_pkg::*;
#(
  parameter int COMMA_COUNT   = 16,
  parameter int SKIP_INTERVAL = 1024,
  parameter int SKIP_LEN      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  enc_data,
  output logic        enc_k,
  output logic        enc_valid,
  output logic        link_up,
  output logic [15:0] pkt_count
);

  localparam logic [7:0] COMMA_LAST = 8'(COMMA_COUNT - 1);
  localparam logic [2:0] SKIP_LAST  = 3'(SKIP_LEN - 1);

  seq_state_e  state_q, state_d;
  logic [7:0]  comma_q, comma_d;
  logic [2:0]  skip_q, skip_d;
  logic        link_q, link_d;
  logic [15:0] pkt_q, pkt_d;
  logic [7:0]  enc_data_q, sym_data;
  logic        enc_k_q, sym_k;
  logic        enc_valid_q;
  logic        skip_pending, skip_clear;

  skip_timer #(.SKIP_INTERVAL(SKIP_INTERVAL)) u_skip_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (skip_clear),
    .pending (skip_pending)
  );

  // Next state and the symbol owed for the current state
  always_comb begin
    state_d    = state_q;
    comma_d    = comma_q;
    skip_d     = skip_q;
    link_d     = link_q;
    pkt_d      = pkt_q;
    sym_data   = K28_5;
    sym_k      = 1'b1;
    skip_clear = 1'b0;
    case (state_q)
      ST_INIT: begin
        comma_d = comma_q + 8'd1;
        if (comma_q == COMMA_LAST) begin
          link_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        skip_d = 3'd0;
        if (skip_pending)             state_d = ST_SKIP;
        else if (enable && in_valid)  state_d = ST_SOF;
      end
      ST_SOF: begin
        sym_data = K27_7;
        state_d  = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (in_valid) begin
          sym_data = in_data;
          sym_k    = 1'b0;
          if (in_last) state_d = ST_EOF;
        end else begin
          sym_data = K23_7;
        end
      end
      ST_EOF: begin
        sym_data = K29_7;
        pkt_d    = pkt_q + 16'd1;
        skip_d   = 3'd0;
        state_d  = skip_pending ? ST_SKIP : ST_IDLE;
      end
      ST_SKIP: begin
        sym_data = K28_0;
        skip_d   = skip_q + 3'd1;
        if (skip_q == SKIP_LAST) begin
          skip_clear = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State, counters and the registered encoder-facing symbol
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      comma_q     <= 8'd0;
      skip_q      <= 3'd0;
      link_q      <= 1'b0;
      pkt_q       <= 16'd0;
      enc_data_q  <= K28_5;
      enc_k_q     <= 1'b1;
      enc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_q     <= comma_d;
      skip_q      <= skip_d;
      link_q      <= link_d;
      pkt_q       <= pkt_d;
      enc_data_q  <= sym_data;
      enc_k_q     <= sym_k;
      enc_valid_q <= 1'b1;
    end
  end

  assign in_ready  = (state_q == ST_PAYLOAD) && !reset;
  assign enc_data  = enc_data_q;
  assign enc_k     = enc_k_q;
  assign enc_valid = enc_valid_q;
  assign link_up   = link_q;
  assign pkt_count = pkt_q;

endmodule
